// File: rtl/cpci_reg_master.sv
// cpci_reg_master: CPCI-side initiator turning host register requests into NF2 register-bus pin cycles
// Ports: pci_clk/reset (sync, active-high); host side req_valid/req_ready/req_rd_wr_L/req_addr/req_wr_data,
// resp_valid/resp_rd_data/resp_timeout; NF2 pins cpci_req/cpci_rd_wr_L/cpci_addr/cpci_wr_data/cpci_data_oe
// (outputs, all flops) and cpci_wr_rdy/cpci_rd_rdy/cpci_rd_data (inputs, registered once); timeout_cnt.
module cpci_reg_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RD_GAP_CYCLES = 2
) (
  input  logic                  pci_clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  output logic                  resp_timeout,
  output logic                  cpci_req,
  output logic                  cpci_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] cpci_addr,
  output logic [DATA_WIDTH-1:0] cpci_wr_data,
  output logic                  cpci_data_oe,
  input  logic                  cpci_wr_rdy,
  input  logic                  cpci_rd_rdy,
  input  logic [DATA_WIDTH-1:0] cpci_rd_data,
  output logic [7:0]            timeout_cnt
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + RD_GAP_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RD_GAP_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(32'hDEAD_BEEF);
  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] ctr, ctr_n;
  logic wr_rdy_q, rd_rdy_q, stale, stale_n, accept;
  logic [DATA_WIDTH-1:0] rd_data_q, wd_n, rd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic req_n, rw_n, oe_n, rv_n, to_n;
  logic [7:0] tcnt_n;
  // a stale reply from an aborted read may still arrive, so reads wait until it has been absorbed
  assign req_ready = !reset && wr_rdy_q && (state == IDLE || state == WR) && !(req_rd_wr_L && stale);
  assign accept = req_valid && req_ready;
  always_comb begin
    state_n = state;
    ctr_n = ctr;
    req_n = cpci_req;
    rw_n = cpci_rd_wr_L;
    addr_n = cpci_addr;
    wd_n = cpci_wr_data;
    oe_n = cpci_data_oe;
    rv_n = 1'b0;
    rd_n = resp_rd_data;
    to_n = resp_timeout;
    stale_n = (stale && rd_rdy_q && state != RD_WAIT) ? 1'b0 : stale;
    tcnt_n = timeout_cnt;
    unique case (state)
      IDLE, WR: begin
        req_n = accept;
        oe_n = accept && !req_rd_wr_L;
        ctr_n = '0;
        state_n = !accept ? IDLE : req_rd_wr_L ? RD_WAIT : WR;
        if (accept) begin
          rw_n = req_rd_wr_L;
          addr_n = req_addr;
          wd_n = req_rd_wr_L ? cpci_wr_data : req_wr_data;
        end
      end
      RD_WAIT: begin
        if (rd_rdy_q || ctr == TO_LAST) begin
          rv_n = 1'b1;
          to_n = !rd_rdy_q;
          rd_n = rd_rdy_q ? rd_data_q : TO_DATA;
          req_n = 1'b0;
          stale_n = !rd_rdy_q;
          tcnt_n = rd_rdy_q ? timeout_cnt : timeout_cnt + {7'd0, ~&timeout_cnt};
          ctr_n = '0;
          state_n = RD_GAP;
        end else begin
          ctr_n = ctr + CW'(1);
        end
      end
      RD_GAP: begin
        state_n = (ctr == GAP_LAST) ? IDLE : RD_GAP;
        ctr_n = ctr + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pci_clk) begin
    if (reset) begin
      state <= IDLE;
      ctr <= '0;
      wr_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      rd_data_q <= '0;
      stale <= 1'b0;
      cpci_req <= 1'b0;
      cpci_rd_wr_L <= 1'b0;
      cpci_addr <= '0;
      cpci_wr_data <= '0;
      cpci_data_oe <= 1'b0;
      resp_valid <= 1'b0;
      resp_rd_data <= '0;
      resp_timeout <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state <= state_n;
      ctr <= ctr_n;
      wr_rdy_q <= cpci_wr_rdy;
      rd_rdy_q <= cpci_rd_rdy;
      rd_data_q <= cpci_rd_data;
      stale <= stale_n;
      cpci_req <= req_n;
      cpci_rd_wr_L <= rw_n;
      cpci_addr <= addr_n;
      cpci_wr_data <= wd_n;
      cpci_data_oe <= oe_n;
      resp_valid <= rv_n;
      resp_rd_data <= rd_n;
      resp_timeout <= to_n;
      timeout_cnt <= tcnt_n;
    end
  end
endmodule

// File: tb/tb_cpci_reg_master.sv
// tb_cpci_reg_master: randomized self-checking bench for cpci_reg_master with an NF2 pin model
module tb_cpci_reg_master;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 1024;
  localparam int GAP = 2;
  logic pci_clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_rd_wr_L = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wr_data = '0;
  logic cpci_wr_rdy = 1'b1, cpci_rd_rdy = 1'b0;
  logic [DW-1:0] cpci_rd_data = '0;
  logic req_ready, resp_valid, resp_timeout, cpci_req, cpci_rd_wr_L, cpci_data_oe;
  logic [DW-1:0] resp_rd_data, cpci_wr_data;
  logic [AW-1:0] cpci_addr;
  logic [7:0] timeout_cnt;
  int checks = 0, fails = 0, model_tcnt = 0;
  logic [AW+DW-1:0] wr_q[$], exp_wr[$];
  logic [DW:0] resp_q[$];
  int low_run = 0, hi_run = 0, last_gap = 0, last_burst = 0, oe_bad = 0;
  logic prev_req = 1'b0;
  always #5 pci_clk = ~pci_clk;
  cpci_reg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .RD_GAP_CYCLES(GAP)) dut (
    .pci_clk(pci_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_wr_L(req_rd_wr_L), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .resp_valid(resp_valid), .resp_rd_data(resp_rd_data), .resp_timeout(resp_timeout),
    .cpci_req(cpci_req), .cpci_rd_wr_L(cpci_rd_wr_L), .cpci_addr(cpci_addr),
    .cpci_wr_data(cpci_wr_data), .cpci_data_oe(cpci_data_oe), .cpci_wr_rdy(cpci_wr_rdy),
    .cpci_rd_rdy(cpci_rd_rdy), .cpci_rd_data(cpci_rd_data), .timeout_cnt(timeout_cnt)
  );
  // NF2-side observer: every cycle with req high and rd_wr_L low is one register write
  always @(negedge pci_clk) begin
    if (!reset && cpci_req && !cpci_rd_wr_L) wr_q.push_back({cpci_addr, cpci_wr_data});
    if (cpci_data_oe && (cpci_rd_wr_L || !cpci_req)) oe_bad++;
    if (resp_valid) resp_q.push_back({resp_timeout, resp_rd_data});
    if (cpci_req) begin
      if (!prev_req) last_gap = low_run;
      hi_run++;
      low_run = 0;
    end else begin
      if (prev_req) last_burst = hi_run;
      hi_run = 0;
      low_run++;
    end
    prev_req = cpci_req;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge pci_clk);
      #1;
    end
  endtask
  task automatic send(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input int limit,
                      output bit ok, output int tries);
    req_valid = 1'b1;
    req_rd_wr_L = rw;
    req_addr = a;
    req_wr_data = d;
    ok = 1'b0;
    tries = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      #1;
      ok = req_ready;
      tries++;
      cyc();
    end
    req_valid = 1'b0;
    if (ok && !rw) exp_wr.push_back({a, d});
  endtask
  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b1;
    cyc(3);
    checks++;
    if ({cpci_req, cpci_rd_wr_L, cpci_data_oe, resp_valid, resp_timeout} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000", {cpci_req, cpci_rd_wr_L, cpci_data_oe, resp_valid, resp_timeout});
    end
    checks++;
    if ({cpci_addr, cpci_wr_data, resp_rd_data, timeout_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_busses: addr %h wdata %h rdata %h tcnt %0d want all 0", cpci_addr, cpci_wr_data, resp_rd_data, timeout_cnt);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    cyc(2);
    checks++;
    if (cpci_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: cpci_req %b want 0", cpci_req);
    end
  endtask
  task automatic test_single_write;
    bit ok;
    int t;
    send(1'b0, 27'h000_0040, 32'hCAFE_0001, 4, ok, t);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL single_write_accept: ok %b want 1", ok);
    end
    checks++;
    if ({cpci_req, cpci_rd_wr_L, cpci_data_oe, cpci_addr, cpci_wr_data} !== {3'b101, 27'h000_0040, 32'hCAFE_0001}) begin
      fails++;
      $display("FAIL single_write_pins: req %b rw %b oe %b addr %h data %h want 1 0 1 0000040 cafe0001",
               cpci_req, cpci_rd_wr_L, cpci_data_oe, cpci_addr, cpci_wr_data);
    end
    cyc();
    checks++;
    if ({cpci_req, cpci_data_oe} !== 2'b00) begin
      fails++;
      $display("FAIL single_write_release: req %b oe %b want 0 0", cpci_req, cpci_data_oe);
    end
    cyc();
    checks++;
    if (last_burst !== 1) begin
      fails++;
      $display("FAIL single_write_len: req high %0d cycles want 1", last_burst);
    end
  endtask
  task automatic test_back_to_back;
    bit ok;
    int t, n, acc;
    logic [AW-1:0] base;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 4 : int'($urandom_range(2, 7));
      base = AW'($urandom);
      acc = 0;
      for (int i = 0; i < n; i++) begin
        send(1'b0, base + AW'(i), $urandom, 1, ok, t);
        acc += int'(ok);
      end
      cyc(2);
      checks++;
      if (acc !== n || last_burst !== n) begin
        fails++;
        $display("FAIL back_to_back: accepted %0d burst %0d want %0d and %0d", acc, last_burst, n, n);
      end
    end
  endtask
  task automatic test_read;
    bit ok;
    int t;
    logic [DW-1:0] d;
    resp_q.delete();
    send(1'b1, 27'h000_0100, '0, 4, ok, t);
    checks++;
    if (!ok || {cpci_req, cpci_rd_wr_L, cpci_data_oe, cpci_addr} !== {3'b110, 27'h000_0100}) begin
      fails++;
      $display("FAIL read_issue: ok %b req %b rw %b oe %b addr %h want 1 1 1 0 0000100", ok, cpci_req, cpci_rd_wr_L, cpci_data_oe, cpci_addr);
    end
    cyc(10);
    cpci_rd_rdy = 1'b1;
    cpci_rd_data = 32'h1234_5678;
    cyc();
    cpci_rd_rdy = 1'b0;
    cpci_rd_data = $urandom;
    checks++;
    if (resp_valid !== 1'b0 || cpci_req !== 1'b1) begin
      fails++;
      $display("FAIL read_early: resp_valid %b req %b want 0 1", resp_valid, cpci_req);
    end
    cyc();
    checks++;
    if ({resp_valid, resp_timeout, resp_rd_data, cpci_req} !== {2'b10, 32'h1234_5678, 1'b0}) begin
      fails++;
      $display("FAIL read_resp: valid %b timeout %b data %h req %b want 1 0 12345678 0", resp_valid, resp_timeout, resp_rd_data, cpci_req);
    end
    send(1'b0, AW'($urandom), $urandom, 10, ok, t);
    cyc();
    checks++;
    if (!ok || t !== GAP + 1 || last_gap < GAP) begin
      fails++;
      $display("FAIL read_gap: ok %b accepted on try %0d low %0d want 1, %0d, >=%0d", ok, t, last_gap, GAP + 1, GAP);
    end
    for (int r = 0; r < 4; r++) begin
      send(1'b1, AW'($urandom), '0, 10, ok, t);
      cyc($urandom_range(0, 20));
      d = $urandom;
      cpci_rd_rdy = 1'b1;
      cpci_rd_data = d;
      cyc();
      cpci_rd_rdy = 1'b0;
      cyc();
      checks++;
      if (!ok || {resp_valid, resp_timeout, resp_rd_data} !== {2'b10, d}) begin
        fails++;
        $display("FAIL read_random: ok %b valid %b timeout %b data %h want 1 1 0 %h", ok, resp_valid, resp_timeout, resp_rd_data, d);
      end
    end
    cyc(GAP + 1);
    checks++;
    if (resp_q.size() !== 5) begin
      fails++;
      $display("FAIL read_resp_count: got %0d responses want 5", resp_q.size());
    end
  endtask
  task automatic test_timeout;
    bit ok;
    int t, n;
    logic [DW-1:0] d;
    resp_q.delete();
    send(1'b1, AW'($urandom), '0, 4, ok, t);
    n = 0;
    while (!resp_valid && n < TO + 50) begin
      cyc();
      n++;
    end
    model_tcnt++;
    checks++;
    if (n !== TO) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO);
    end
    checks++;
    if ({resp_valid, resp_timeout, resp_rd_data} !== {2'b11, 32'hDEAD_BEEF} || int'(timeout_cnt) !== model_tcnt) begin
      fails++;
      $display("FAIL timeout_resp: valid %b timeout %b data %h cnt %0d want 1 1 deadbeef %0d",
               resp_valid, resp_timeout, resp_rd_data, timeout_cnt, model_tcnt);
    end
    cyc(GAP + 2);
    send(1'b1, AW'($urandom), '0, 30, ok, t);
    checks++;
    if (ok !== 1'b0) begin
      fails++;
      $display("FAIL stale_read_stall: accepted %b want 0", ok);
    end
    send(1'b0, AW'($urandom), $urandom, 4, ok, t);
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL stale_write_accept: accepted %b want 1", ok);
    end
    cyc(2);
    cpci_rd_rdy = 1'b1;
    cpci_rd_data = $urandom;
    cyc();
    cpci_rd_rdy = 1'b0;
    cyc(3);
    checks++;
    if (resp_q.size() !== 1) begin
      fails++;
      $display("FAIL stale_no_resp: got %0d responses want 1", resp_q.size());
    end
    send(1'b1, AW'($urandom), '0, 3, ok, t);
    d = $urandom;
    cpci_rd_rdy = 1'b1;
    cpci_rd_data = d;
    cyc();
    cpci_rd_rdy = 1'b0;
    cyc();
    checks++;
    if (!ok || {resp_valid, resp_timeout, resp_rd_data} !== {2'b10, d}) begin
      fails++;
      $display("FAIL read_after_stale: ok %b valid %b timeout %b data %h want 1 1 0 %h", ok, resp_valid, resp_timeout, resp_rd_data, d);
    end
    cyc(GAP + 1);
  endtask
  task automatic test_flow_ctrl;
    bit ok;
    int t, bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    d = $urandom;
    cpci_wr_rdy = 1'b0;
    cyc(2);
    req_valid = 1'b1;
    req_rd_wr_L = 1'b0;
    req_addr = a;
    req_wr_data = d;
    bad = 0;
    repeat (20) begin
      #1;
      if (req_ready !== 1'b0 || cpci_req !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL wr_rdy_block: %0d cycles with ready/req high want 0", bad);
    end
    cpci_wr_rdy = 1'b1;
    send(1'b0, a, d, 5, ok, t);
    cpci_wr_rdy = 1'b0;
    checks++;
    if (!ok || cpci_req !== 1'b1 || cpci_wr_data !== d) begin
      fails++;
      $display("FAIL wr_rdy_resume: ok %b req %b data %h want 1 1 %h", ok, cpci_req, cpci_wr_data, d);
    end
    cyc(3);
    cpci_wr_rdy = 1'b1;
    cyc(2);
  endtask
  task automatic test_reset_mid_read;
    bit ok;
    int t;
    logic [DW-1:0] d;
    send(1'b1, AW'($urandom), '0, 4, ok, t);
    cyc(5);
    resp_q.delete();
    reset = 1'b1;
    cyc();
    model_tcnt = 0;
    checks++;
    if ({cpci_req, cpci_rd_wr_L, cpci_data_oe, resp_valid, resp_timeout, req_ready} !== 6'b0 ||
        {cpci_addr, cpci_wr_data, resp_rd_data} !== '0 || int'(timeout_cnt) !== model_tcnt) begin
      fails++;
      $display("FAIL reset_mid_read: req %b rw %b oe %b rv %b to %b rdy %b addr %h wd %h rd %h cnt %0d want all 0",
               cpci_req, cpci_rd_wr_L, cpci_data_oe, resp_valid, resp_timeout, req_ready, cpci_addr, cpci_wr_data, resp_rd_data, timeout_cnt);
    end
    reset = 1'b0;
    cyc(2);
    cpci_rd_rdy = 1'b1;
    cyc();
    cpci_rd_rdy = 1'b0;
    cyc(4);
    checks++;
    if (resp_q.size() !== 0) begin
      fails++;
      $display("FAIL reset_drops_read: got %0d responses want 0", resp_q.size());
    end
    send(1'b1, AW'($urandom), '0, 4, ok, t);
    d = $urandom;
    cpci_rd_rdy = 1'b1;
    cpci_rd_data = d;
    cyc();
    cpci_rd_rdy = 1'b0;
    cyc();
    checks++;
    if (!ok || {resp_valid, resp_timeout, resp_rd_data} !== {2'b10, d}) begin
      fails++;
      $display("FAIL read_after_reset: ok %b valid %b timeout %b data %h want 1 1 0 %h", ok, resp_valid, resp_timeout, resp_rd_data, d);
    end
    cyc(GAP + 2);
  endtask
  task automatic test_write_log;
    checks++;
    if (wr_q.size() !== exp_wr.size()) begin
      fails++;
      $display("FAIL write_count: NF2 saw %0d writes want %0d", wr_q.size(), exp_wr.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr[i]) begin
        fails++;
        $display("FAIL write_%0d: got %h want %h", i, wr_q[i], exp_wr[i]);
      end
    end
    checks++;
    if (oe_bad !== 0) begin
      fails++;
      $display("FAIL oe_contention: %0d cycles with oe outside a write want 0", oe_bad);
    end
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_timeout();
    test_flow_ctrl();
    test_reset_mid_read();
    test_write_log();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
